// File: rtl/cntr_ctrl_pkg.sv
// Shared register map, bit positions, FSM state type and byte-lane merge helper
// for the Wishbone-controlled pad counter.
package cntr_ctrl_pkg;

  localparam logic [7:0] OFS_CTRL     = 8'h00;
  localparam logic [7:0] OFS_STATUS   = 8'h04;
  localparam logic [7:0] OFS_LOAD     = 8'h08;
  localparam logic [7:0] OFS_LIMIT    = 8'h0C;
  localparam logic [7:0] OFS_PRESCALE = 8'h10;
  localparam logic [7:0] OFS_COUNT    = 8'h14;
  localparam logic [7:0] OFS_OEB      = 8'h18;

  localparam int CTRL_START  = 32'd0;
  localparam int CTRL_STOP   = 32'd1;
  localparam int CTRL_MODE   = 32'd2;
  localparam int CTRL_DIR    = 32'd3;
  localparam int CTRL_IRQ_EN = 32'd4;
  localparam int STAT_DONE   = 32'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } cntr_state_t;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/cntr_tick_gen.sv
// 16-bit prescaler: emits a single-cycle tick every PRESCALE+1 enabled cycles.
module cntr_tick_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [15:0] prescale,
  output logic        tick
);

  logic [15:0] pre_r;

  // >= rather than == so a PRESCALE lowered mid-run below the current phase
  // ticks immediately instead of wrapping through 65536 cycles.
  assign tick = en & (pre_r >= prescale);

  // Prescaler phase counter
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_r <= 16'h0000;
    end else if (clr) begin
      pre_r <= 16'h0000;
    end else if (en) begin
      pre_r <= tick ? 16'h0000 : pre_r + 16'h0001;
    end
  end

endmodule

// File: rtl/cntr_wb_ctrl.sv
// Wishbone slave that programs and sequences the pad counter: register file,
// run/done FSM, counter, pad output enables and limit-match interrupt.
module cntr_wb_ctrl
  import cntr_ctrl_pkg::*;
#(
  parameter int          WIDTH     = 20,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  output logic [WIDTH-1:0] cnt_o,
  output logic [WIDTH-1:0] io_oeb_o,
  output logic             irq_o
);

  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic             ack_r, irq_r, mode_r, dir_r, irq_en_r, done_flag_r;
  logic [31:0]      dat_r, rd_data_s;
  logic [WIDTH-1:0] load_r, limit_r, oeb_r, count_r, count_nxt_s;
  logic [15:0]      prescale_r;
  cntr_state_t      state_r, state_nxt_s;
  logic             hit_s, access_s, wr_s, ctrl_wr_s, start_s, stop_s, w1c_s;
  logic             run_s, tick_s, done_set_s, done_nxt_s, irq_en_nxt_s;
  logic [7:0]       ofs_s;

  // Full byte offset is decoded, so misaligned addresses fall into the unmapped space.
  assign ofs_s        = wbs_adr_i[7:0];
  assign hit_s        = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign access_s     = hit_s & ~ack_r;
  assign wr_s         = access_s & wbs_we_i;
  assign ctrl_wr_s    = wr_s & (ofs_s == OFS_CTRL) & wbs_sel_i[0];
  assign start_s      = ctrl_wr_s & wbs_dat_i[CTRL_START];
  assign stop_s       = ctrl_wr_s & wbs_dat_i[CTRL_STOP];
  assign w1c_s        = wr_s & (ofs_s == OFS_STATUS) & wbs_sel_i[0] & wbs_dat_i[STAT_DONE];
  assign run_s        = (state_r == ST_RUN);
  assign done_nxt_s   = done_set_s | (done_flag_r & ~w1c_s);
  assign irq_en_nxt_s = ctrl_wr_s ? wbs_dat_i[CTRL_IRQ_EN] : irq_en_r;

  assign wbs_ack_o = ack_r;
  assign wbs_dat_o = dat_r;
  assign cnt_o     = count_r;
  assign io_oeb_o  = oeb_r;
  assign irq_o     = irq_r;

  cntr_tick_gen u_tick (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .clr      (start_s),
    .en       (run_s),
    .prescale (prescale_r),
    .tick     (tick_s)
  );

  // Read-data mux
  always_comb begin
    rd_data_s = 32'h0000_0000;
    case (ofs_s)
      OFS_CTRL:     rd_data_s = {27'h0, irq_en_r, dir_r, mode_r, 2'b00};
      OFS_STATUS:   rd_data_s = {29'h0, done_flag_r, state_r};
      OFS_LOAD:     rd_data_s = 32'(load_r);
      OFS_LIMIT:    rd_data_s = 32'(limit_r);
      OFS_PRESCALE: rd_data_s = {16'h0000, prescale_r};
      OFS_COUNT:    rd_data_s = 32'(count_r);
      OFS_OEB:      rd_data_s = 32'(oeb_r);
      default:      rd_data_s = 32'h0000_0000;
    endcase
  end

  // Run FSM and counter next-state; STOP outranks START, both outrank a tick
  always_comb begin
    state_nxt_s = state_r;
    count_nxt_s = count_r;
    done_set_s  = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (stop_s) begin
          state_nxt_s = ST_IDLE;
        end else if (start_s) begin
          state_nxt_s = ST_RUN;
          count_nxt_s = load_r;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_RUN: begin
        if (stop_s) begin
          state_nxt_s = ST_IDLE;
        end else if (start_s) begin
          count_nxt_s = load_r;
        end else if (tick_s && (count_r == limit_r)) begin
          done_set_s = 1'b1;
          if (mode_r) count_nxt_s = load_r;
          else        state_nxt_s = ST_DONE;
        end else if (tick_s) begin
          count_nxt_s = dir_r ? count_r - CNT_ONE : count_r + CNT_ONE;
        end else begin
          count_nxt_s = count_r;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Wishbone acknowledge and registered read data
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_r <= 1'b0;
      dat_r <= 32'h0000_0000;
    end else begin
      ack_r <= access_s;
      dat_r <= (access_s & ~wbs_we_i) ? rd_data_s : 32'h0000_0000;
    end
  end

  // Configuration registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      load_r     <= {WIDTH{1'b0}};
      limit_r    <= {WIDTH{1'b0}};
      oeb_r      <= {WIDTH{1'b1}};
      prescale_r <= 16'h0000;
      mode_r     <= 1'b0;
      dir_r      <= 1'b0;
      irq_en_r   <= 1'b0;
    end else begin
      if (wr_s && ofs_s == OFS_LOAD)
        load_r <= WIDTH'(merge_bytes(32'(load_r), wbs_dat_i, wbs_sel_i));
      if (wr_s && ofs_s == OFS_LIMIT)
        limit_r <= WIDTH'(merge_bytes(32'(limit_r), wbs_dat_i, wbs_sel_i));
      if (wr_s && ofs_s == OFS_OEB)
        oeb_r <= WIDTH'(merge_bytes(32'(oeb_r), wbs_dat_i, wbs_sel_i));
      if (wr_s && ofs_s == OFS_PRESCALE)
        prescale_r <= 16'(merge_bytes({16'h0000, prescale_r}, wbs_dat_i, wbs_sel_i));
      if (ctrl_wr_s) begin
        mode_r <= wbs_dat_i[CTRL_MODE];
        dir_r  <= wbs_dat_i[CTRL_DIR];
      end
      irq_en_r <= irq_en_nxt_s;
    end
  end

  // State, count, sticky done flag and interrupt
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_r     <= ST_IDLE;
      count_r     <= {WIDTH{1'b0}};
      done_flag_r <= 1'b0;
      irq_r       <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      count_r     <= count_nxt_s;
      done_flag_r <= done_nxt_s;
      irq_r       <= done_nxt_s & irq_en_nxt_s;
    end
  end

endmodule

// File: tb/tb_cntr_wb_ctrl.sv
// Self-checking bench for cntr_wb_ctrl: register table plus timed run/done,
// periodic, stop, W1C race and reset sequences.
module tb_cntr_wb_ctrl;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [7:0] CTRL = 8'h00, STATUS = 8'h04, LOAD = 8'h08, LIMIT = 8'h0C;
  localparam logic [7:0] PRESC = 8'h10, COUNT = 8'h14, OEB = 8'h18, UNMAP = 8'h1C;

  logic        clk = 1'b0;
  logic        rst, cyc, stb, we, ack, irq;
  logic [3:0]  sel;
  logic [31:0] adr, dat_i, dat_o;
  logic [19:0] cnt, oeb;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        we;
    logic [7:0]  ofs;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  cntr_wb_ctrl #(.WIDTH(20), .BASE_ADDR(32'h3000_0000)) dut (
    .wb_clk_i (clk),  .wb_rst_i (rst),
    .wbs_cyc_i(cyc),  .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel),  .wbs_adr_i(adr), .wbs_dat_i(dat_i),
    .wbs_ack_o(ack),  .wbs_dat_o(dat_o),
    .cnt_o    (cnt),  .io_oeb_o (oeb), .irq_o   (irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Access edge is the first posedge after the call; returns 1ns after the ack edge
  // (or after one extra held cycle when hold is set, checking ack dropped).
  task automatic wb_xfer(input logic w, input logic [7:0] ofs, input logic [31:0] d,
                         input logic [3:0] s, input logic [31:0] e, input bit hold,
                         input string name);
    logic [31:0] e_pop;
    bit got;
    if (!w) exp_q.push_back(e);
    cyc = 1'b1; stb = 1'b1; we = w; adr = BASE | {24'h0, ofs}; dat_i = d; sel = s;
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      step();
      got = ack;
    end
    if (!got) begin
      n_vec++; n_err++;
      $display("FAIL %s: no ack within 4 cycles, expected ack", name);
      if (!w) e_pop = exp_q.pop_front();
    end else if (!w) begin
      e_pop = exp_q.pop_front();
      check(name, dat_o, e_pop);
    end
    if (hold) begin
      step();
      check({name, "_ack_width"}, 32'(ack), 32'h0);
      if (!w) check({name, "_dat_idle"}, dat_o, 32'h0);
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  function automatic vec_t mk(input logic w, input logic [7:0] o, input logic [31:0] d,
                              input logic [3:0] s, input logic [31:0] e);
    vec_t v;
    v.we = w; v.ofs = o; v.dat = d; v.sel = s; v.exp = e;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    logic [19:0] seq [6];
    seq = '{20'h00002, 20'h00001, 20'h00000, 20'hFFFFF, 20'hFFFFE, 20'h00002};

    vecs.push_back(mk(1'b0, CTRL,   32'h0,          4'hF, 32'h0));
    vecs.push_back(mk(1'b0, STATUS, 32'h0,          4'hF, 32'h0));
    vecs.push_back(mk(1'b0, LOAD,   32'h0,          4'hF, 32'h0));
    vecs.push_back(mk(1'b0, LIMIT,  32'h0,          4'hF, 32'h0));
    vecs.push_back(mk(1'b0, PRESC,  32'h0,          4'hF, 32'h0));
    vecs.push_back(mk(1'b0, COUNT,  32'h0,          4'hF, 32'h0));
    vecs.push_back(mk(1'b0, OEB,    32'h0,          4'hF, 32'h000F_FFFF));
    vecs.push_back(mk(1'b0, UNMAP,  32'h0,          4'hF, 32'h0));
    vecs.push_back(mk(1'b1, LOAD,   32'hAABB_CCDD,  4'h1, 32'h0));
    vecs.push_back(mk(1'b0, LOAD,   32'h0,          4'hF, 32'h0000_00DD));
    vecs.push_back(mk(1'b1, LOAD,   32'h1122_3344,  4'hE, 32'h0));
    vecs.push_back(mk(1'b0, LOAD,   32'h0,          4'hF, 32'h0002_33DD));
    vecs.push_back(mk(1'b1, OEB,    32'h0012_3400,  4'h6, 32'h0));
    vecs.push_back(mk(1'b0, OEB,    32'h0,          4'hF, 32'h0002_34FF));
    vecs.push_back(mk(1'b1, PRESC,  32'hFFFF_FFFF,  4'hF, 32'h0));
    vecs.push_back(mk(1'b0, PRESC,  32'h0,          4'hF, 32'h0000_FFFF));
    vecs.push_back(mk(1'b1, PRESC,  32'h0,          4'h1, 32'h0));
    vecs.push_back(mk(1'b0, PRESC,  32'h0,          4'hF, 32'h0000_FF00));
    vecs.push_back(mk(1'b1, LIMIT,  32'hFFFF_FFFF,  4'hF, 32'h0));
    vecs.push_back(mk(1'b0, LIMIT,  32'h0,          4'hF, 32'h000F_FFFF));
    vecs.push_back(mk(1'b1, COUNT,  32'h0000_0055,  4'hF, 32'h0));
    vecs.push_back(mk(1'b0, COUNT,  32'h0,          4'hF, 32'h0));
    vecs.push_back(mk(1'b1, UNMAP,  32'hFFFF_FFFF,  4'hF, 32'h0));
    vecs.push_back(mk(1'b0, UNMAP,  32'h0,          4'hF, 32'h0));
    vecs.push_back(mk(1'b1, CTRL,   32'h0000_001E,  4'h1, 32'h0));
    vecs.push_back(mk(1'b0, CTRL,   32'h0,          4'hF, 32'h0000_001C));
    vecs.push_back(mk(1'b1, CTRL,   32'h0,          4'h1, 32'h0));
    vecs.push_back(mk(1'b0, CTRL,   32'h0,          4'hF, 32'h0));

    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'h0; dat_i = 32'h0;
    repeat (3) step();
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_dat", dat_o, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_cnt", 32'(cnt), 32'h0);
    check("rst_oeb", 32'(oeb), 32'h000F_FFFF);
    rst = 1'b0;
    step();

    for (int i = 0; i < vecs.size(); i++)
      wb_xfer(vecs[i].we, vecs[i].ofs, vecs[i].dat, vecs[i].sel, vecs[i].exp, 1'b1,
              $sformatf("vec%0d", i));
    check("oeb_pins", 32'(oeb), 32'h0002_34FF);

    // Outside the window: no ack at all
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0100;
    for (int i = 0; i < 3; i++) begin
      step();
      check("oow_ack", 32'(ack), 32'h0);
    end
    cyc = 1'b0; stb = 1'b0;

    // One-shot up 5..9, prescale 0
    wb_xfer(1'b1, LOAD,  32'd5, 4'hF, 32'h0, 1'b0, "os_load");
    wb_xfer(1'b1, LIMIT, 32'd9, 4'hF, 32'h0, 1'b0, "os_limit");
    wb_xfer(1'b1, PRESC, 32'd0, 4'hF, 32'h0, 1'b0, "os_presc");
    wb_xfer(1'b1, CTRL,  32'h10, 4'h1, 32'h0, 1'b0, "os_cfg");
    wb_xfer(1'b1, CTRL,  32'h11, 4'h1, 32'h0, 1'b0, "os_start");
    check("os_cnt_load", 32'(cnt), 32'd5);
    check("os_irq_low", 32'(irq), 32'h0);
    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("os_cnt_step%0d", k), 32'(cnt), 32'(5 + k));
    end
    step();
    check("os_cnt_hold", 32'(cnt), 32'd9);
    check("os_irq", 32'(irq), 32'h1);
    wb_xfer(1'b0, STATUS, 32'h0, 4'hF, 32'h6, 1'b0, "os_status_done");
    wb_xfer(1'b0, COUNT,  32'h0, 4'hF, 32'd9, 1'b0, "os_count_rd");
    wb_xfer(1'b1, STATUS, 32'h4, 4'h1, 32'h0, 1'b0, "os_w1c");
    check("os_irq_cleared", 32'(irq), 32'h0);
    wb_xfer(1'b0, STATUS, 32'h0, 4'hF, 32'h2, 1'b0, "os_status_clr");

    // Periodic down through wrap, prescale 3
    wb_xfer(1'b1, LOAD,  32'd2,        4'hF, 32'h0, 1'b0, "pd_load");
    wb_xfer(1'b1, LIMIT, 32'h000F_FFFE, 4'hF, 32'h0, 1'b0, "pd_limit");
    wb_xfer(1'b1, PRESC, 32'd3,        4'hF, 32'h0, 1'b0, "pd_presc");
    wb_xfer(1'b1, CTRL,  32'h0D,       4'h1, 32'h0, 1'b0, "pd_start");
    check("pd_cnt_load", 32'(cnt), 32'd2);
    for (int k = 1; k <= 21; k++) begin
      step();
      check($sformatf("pd_cnt_c%0d", k), 32'(cnt), 32'(seq[k/4]));
    end
    wb_xfer(1'b0, STATUS, 32'h0, 4'hF, 32'h5, 1'b0, "pd_status_run");

    // START|STOP together while running: stop wins, count frozen at 0
    repeat (6) step();
    wb_xfer(1'b1, CTRL, 32'h0F, 4'h1, 32'h0, 1'b0, "ss_write");
    check("ss_cnt", 32'(cnt), 32'h0);
    repeat (5) step();
    check("ss_cnt_frozen", 32'(cnt), 32'h0);
    wb_xfer(1'b0, STATUS, 32'h0, 4'hF, 32'h4, 1'b0, "ss_status_idle");

    // W1C landing on the same edge as the matching tick: set wins
    wb_xfer(1'b1, STATUS, 32'h4, 4'h1, 32'h0, 1'b0, "race_clr");
    wb_xfer(1'b1, LOAD,  32'd0, 4'hF, 32'h0, 1'b0, "race_load");
    wb_xfer(1'b1, LIMIT, 32'd1, 4'hF, 32'h0, 1'b0, "race_limit");
    wb_xfer(1'b1, PRESC, 32'd0, 4'hF, 32'h0, 1'b0, "race_presc");
    wb_xfer(1'b1, CTRL,  32'h11, 4'h1, 32'h0, 1'b0, "race_start");
    check("race_cnt0", 32'(cnt), 32'd0);
    step();
    check("race_cnt1", 32'(cnt), 32'd1);
    wb_xfer(1'b1, STATUS, 32'h4, 4'h1, 32'h0, 1'b0, "race_w1c");
    check("race_irq", 32'(irq), 32'h1);
    wb_xfer(1'b0, STATUS, 32'h0, 4'hF, 32'h6, 1'b0, "race_status");

    // Reset in the middle of a run
    wb_xfer(1'b1, LOAD,  32'h0001_2345, 4'hF, 32'h0, 1'b0, "mr_load");
    wb_xfer(1'b1, LIMIT, 32'h0,        4'hF, 32'h0, 1'b0, "mr_limit");
    wb_xfer(1'b1, PRESC, 32'h0000_FFFF, 4'hF, 32'h0, 1'b0, "mr_presc");
    wb_xfer(1'b1, CTRL,  32'h11,       4'h1, 32'h0, 1'b0, "mr_start");
    check("mr_cnt_run", 32'(cnt), 32'h0001_2345);
    check("mr_irq_before", 32'(irq), 32'h1);
    rst = 1'b1;
    step();
    check("mr_cnt", 32'(cnt), 32'h0);
    check("mr_oeb", 32'(oeb), 32'h000F_FFFF);
    check("mr_irq", 32'(irq), 32'h0);
    rst = 1'b0;
    wb_xfer(1'b0, STATUS, 32'h0, 4'hF, 32'h0,        1'b1, "mr_status");
    wb_xfer(1'b0, CTRL,   32'h0, 4'hF, 32'h0,        1'b1, "mr_ctrl");
    wb_xfer(1'b0, LOAD,   32'h0, 4'hF, 32'h0,        1'b1, "mr_load_rd");
    wb_xfer(1'b0, PRESC,  32'h0, 4'hF, 32'h0,        1'b1, "mr_presc_rd");
    wb_xfer(1'b0, OEB,    32'h0, 4'hF, 32'h000F_FFFF, 1'b1, "mr_oeb_rd");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cntr_wb_ctrl.md
# cntr_wb_ctrl

Wishbone-slave controller that configures and sequences the 20-bit pad counter driven onto `io_out[19:0]` in the user project wrapper. Firmware programs load value, limit, prescale, direction and mode over the Caravel Wishbone port. The block runs the count, drives the pad bits and their output enables, and raises a user IRQ on limit match. It replaces the free-running counter with a software-controlled one.

## Interface
Parameters:
- `WIDTH`, 20, counter and pad width (≤32).
- `BASE_ADDR`, 32'h3000_0000, Wishbone window base; the block decodes `wbs_adr_i[31:8] == BASE_ADDR[31:8]`.

Ports:
- `wb_clk_i`  in  1  sole clock.
- `wb_rst_i`  in  1  reset, synchronous, active-high.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i`  in  1 each  Wishbone classic strobes.
- `wbs_sel_i`  in  4  byte lane enables.
- `wbs_adr_i`  in  32  byte address.
- `wbs_dat_i`  in  32  write data.
- `wbs_ack_o`  out  1  transfer acknowledge.
- `wbs_dat_o`  out  32  read data.
- `cnt_o`  out  WIDTH  current count, drives `io_out[WIDTH-1:0]`.
- `io_oeb_o`  out  WIDTH  pad output-enable bar, drives `io_oeb[WIDTH-1:0]`.
- `irq_o`  out  1  level interrupt, drives `user_irq[0]`.

## Operation
Register map (word offsets):
- 0x00 CTRL
  - Bit 0 START and bit 1 STOP are self-clearing strobes that read back 0.
  - Bit 2 MODE: 0 one-shot, 1 periodic.
  - Bit 3 DIR: 0 up, 1 down.
  - Bit 4 IRQ_EN.
- 0x04 STATUS
  - Bits [1:0] state: 0 IDLE, 1 RUN, 2 DONE.
  - Bit 2 DONE_FLAG, sticky, write-1-to-clear.
- 0x08 LOAD, 0x0C LIMIT, 0x18 OEB: WIDTH bits each, byte-lane writable.
- 0x10 PRESCALE: 16 bits, byte-lane writable.
- 0x14 COUNT: read-only.
- Unmapped offsets inside the window: reads return 0, writes are ignored, and the access is still acked.

FSM:
- IDLE
  - START: count ← LOAD, prescaler ← 0, go to RUN.
- RUN
  - A tick occurs when the prescaler equals PRESCALE; the prescaler then returns to 0.
  - On tick with count == LIMIT: set DONE_FLAG.
    - One-shot: go to DONE and hold count.
    - Periodic: count ← LOAD and stay in RUN.
  - On tick with count ≠ LIMIT: count ± 1, wrapping modulo 2^WIDTH.
  - STOP: go to IDLE and hold count.
  - START: restart (reload and clear prescaler).
- DONE
  - START behaves as in IDLE.
  - STOP: go to IDLE.

Rules:
- START and STOP written in the same cycle: STOP wins.
- LOAD, LIMIT and PRESCALE writes during RUN take effect at the next compare, tick or reload. The current count is not altered.
- DONE_FLAG set and W1C in the same cycle: set wins.
- `irq_o` = DONE_FLAG & IRQ_EN.
- `io_oeb_o` = OEB register.

## Timing
- Reset values:
  - count, LOAD, LIMIT, PRESCALE, CTRL, DONE_FLAG all 0; state IDLE.
  - OEB all ones (pads tristated).
  - `wbs_ack_o` 0, `wbs_dat_o` 0, `irq_o` 0.
- Reset mid-RUN returns to IDLE on the next edge with the above values.
- Wishbone handshake:
  - `wbs_ack_o` asserts one cycle after `cyc & stb & addr-hit & !ack` and lasts exactly one cycle.
  - Back-to-back transfers therefore take two cycles each.
  - Write data and strobes take effect on the ack edge.
  - `wbs_dat_o` is registered, valid while ack is high, and 0 otherwise.
- START at edge N: state = RUN and count = LOAD visible at N+1. With PRESCALE = P, the first change occurs at N+1+(P+1).
- Count on one-shot match: the DONE transition and DONE_FLAG are visible the cycle after the matching tick; `irq_o` goes high in that same cycle.
- `cnt_o` is a register output with no combinational path from the Wishbone inputs.

## Structure
- Package `cntr_ctrl_pkg` holds:
  - register offset constants;
  - CTRL and STATUS bit positions;
  - the `cntr_state_t` enum {IDLE, RUN, DONE}.
- Sub-module `cntr_tick_gen` is the 16-bit prescaler.
  - Inputs: `clr`, `en`, `prescale`.
  - Output: single-cycle `tick`.
- The top level holds the Wishbone decode, registers, FSM and counter.

## Test plan
- Reset, then read all registers: OEB = 0xFFFFF, all others 0, ack exactly 1 cycle per access, `irq_o` = 0.
- LOAD = 5, LIMIT = 9, PRESCALE = 0, one-shot up, IRQ_EN, START:
  - `cnt_o` steps 5→9 on consecutive cycles;
  - state DONE one cycle later, count holds at 9;
  - `irq_o` = 1;
  - W1C STATUS bit 2 drops `irq_o`.
- Periodic down, LOAD = 2, LIMIT = 0xFFFFE, PRESCALE = 3:
  - count 2,1,0,0xFFFFF,0xFFFFE, changing every 4 cycles;
  - then reloads 2 and stays in RUN.
- Write CTRL = 0x03 (START | STOP) while RUN → state IDLE, count frozen.
- DONE_FLAG W1C issued in the same cycle as a matching tick → DONE_FLAG stays 1.
- Assert `wb_rst_i` mid-RUN with count = 0x12345 → next cycle state IDLE, `cnt_o` = 0, OEB = 0xFFFFF.
